// File: rtl/i2s_capture_if.sv
// Bus bundle for i2s_capture: the serial codec pins plus the parallel stereo frame outputs.
// The peak meter signals exist only when I2S_CAPTURE_PEAK_EN is defined.
`timescale 1ns/1ps
interface i2s_capture_if #(
    parameter int SAMPLE_WIDTH = 24
);
    logic                    i2s_bclk;
    logic                    i2s_lr;
    logic                    i2s_sdata;
    logic [SAMPLE_WIDTH-1:0] left_sample;
    logic [SAMPLE_WIDTH-1:0] right_sample;
    logic                    sample_valid;
    logic                    frame_error;
`ifdef I2S_CAPTURE_PEAK_EN
    logic [SAMPLE_WIDTH-2:0] peak_level;
    logic                    peak_clear;

    modport master (
        input  i2s_bclk, i2s_lr, i2s_sdata, peak_clear,
        output left_sample, right_sample, sample_valid, frame_error, peak_level
    );
    modport slave (
        output i2s_bclk, i2s_lr, i2s_sdata, peak_clear,
        input  left_sample, right_sample, sample_valid, frame_error, peak_level
    );
`else
    modport master (
        input  i2s_bclk, i2s_lr, i2s_sdata,
        output left_sample, right_sample, sample_valid, frame_error
    );
    modport slave (
        output i2s_bclk, i2s_lr, i2s_sdata,
        input  left_sample, right_sample, sample_valid, frame_error
    );
`endif
endinterface

// File: rtl/i2s_capture.sv
// I2S receiver: synchronizes bclk/lr/sdata into clk, deserializes left/right words and strobes each
// completed stereo frame. Define I2S_CAPTURE_PEAK_EN to add a left-channel peak meter.
`timescale 1ns/1ps
module i2s_capture #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_BITS    = 32
) (
    input  logic          clk,
    input  logic          reset,
    i2s_capture_if.master bus
);
    localparam int CNT_W = $clog2(SLOT_BITS + 2);

    typedef enum logic [1:0] {WAIT_SYNC, DELAY, SHIFT, PAD} state_t;

    // Bit 0 = bclk, bit 1 = lr, bit 2 = sdata
    logic [2:0] pin_vec;
    logic [2:0] sync2_vec;
    logic [2:0] hist_vec;

    assign pin_vec = {bus.i2s_sdata, bus.i2s_lr, bus.i2s_bclk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            logic h_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                    h_reg  <= 1'b0;
                end else begin
                    s1_reg <= pin_vec[gi];
                    s2_reg <= s1_reg;
                    h_reg  <= s2_reg;
                end
            end
            assign sync2_vec[gi] = s2_reg;
            assign hist_vec[gi]  = h_reg;
        end
    endgenerate

    // lr/sdata are stable for half a bclk around the rise, so the history stage is a safe sample point.
    logic bclk_rise;
    logic lr_now;
    logic sdata_now;
    logic lr_prev_reg;
    logic lr_change;

    assign bclk_rise = sync2_vec[0] & ~hist_vec[0];
    assign lr_now    = hist_vec[1];
    assign sdata_now = hist_vec[2];
    assign lr_change = lr_now ^ lr_prev_reg;

    state_t                  state_reg;
    logic [CNT_W-1:0]        bit_cnt_reg;
    logic                    chan_reg;
    logic                    have_left_reg;
    logic [SAMPLE_WIDTH-2:0] shreg_reg;
    logic [SAMPLE_WIDTH-1:0] left_hold_reg;
    logic [SAMPLE_WIDTH-1:0] left_sample_reg;
    logic [SAMPLE_WIDTH-1:0] right_sample_reg;
    logic                    sample_valid_reg;
    logic                    frame_error_reg;
    logic [SAMPLE_WIDTH-1:0] shift_word;

    assign shift_word = {shreg_reg, sdata_now};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= WAIT_SYNC;
            bit_cnt_reg      <= '0;
            chan_reg         <= 1'b0;
            have_left_reg    <= 1'b0;
            lr_prev_reg      <= 1'b0;
            shreg_reg        <= '0;
            left_hold_reg    <= '0;
            left_sample_reg  <= '0;
            right_sample_reg <= '0;
            sample_valid_reg <= 1'b0;
            frame_error_reg  <= 1'b0;
        end else begin
            sample_valid_reg <= 1'b0;
            frame_error_reg  <= 1'b0;
            if (bclk_rise) begin
                lr_prev_reg <= lr_now;
                case (state_reg)
                    WAIT_SYNC: begin
                        if (lr_change) state_reg <= DELAY;
                    end
                    DELAY: begin
                        bit_cnt_reg <= '0;
                        chan_reg    <= lr_now;
                        state_reg   <= SHIFT;
                    end
                    SHIFT: begin
                        if (lr_change) begin
                            frame_error_reg <= 1'b1;
                            have_left_reg   <= 1'b0;
                            state_reg       <= DELAY;
                        end else begin
                            shreg_reg   <= shift_word[SAMPLE_WIDTH-2:0];
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == CNT_W'(SAMPLE_WIDTH - 1)) begin
                                state_reg <= PAD;
                                if (!chan_reg) begin
                                    left_hold_reg <= shift_word;
                                    have_left_reg <= 1'b1;
                                end else begin
                                    // A right word only counts if its left partner was captured.
                                    if (have_left_reg) begin
                                        left_sample_reg  <= left_hold_reg;
                                        right_sample_reg <= shift_word;
                                        sample_valid_reg <= 1'b1;
                                    end
                                    have_left_reg <= 1'b0;
                                end
                            end
                        end
                    end
                    PAD: begin
                        if (lr_change) begin
                            state_reg <= DELAY;
                        end else if (bit_cnt_reg >= CNT_W'(SLOT_BITS)) begin
                            bit_cnt_reg     <= CNT_W'(SLOT_BITS + 1);
                            frame_error_reg <= 1'b1;
                            state_reg       <= WAIT_SYNC;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                    default: state_reg <= WAIT_SYNC;
                endcase
            end
        end
    end

    assign bus.left_sample  = left_sample_reg;
    assign bus.right_sample = right_sample_reg;
    assign bus.sample_valid = sample_valid_reg;
    assign bus.frame_error  = frame_error_reg;

`ifdef I2S_CAPTURE_PEAK_EN
    logic [SAMPLE_WIDTH-1:0] left_mag;
    logic [SAMPLE_WIDTH-2:0] peak_mag;
    logic [SAMPLE_WIDTH-2:0] peak_level_reg;

    // The most negative code has no positive twin; saturate it to full scale.
    always_comb begin
        left_mag = left_sample_reg[SAMPLE_WIDTH-1] ? (~left_sample_reg + 1'b1) : left_sample_reg;
        peak_mag = left_mag[SAMPLE_WIDTH-1] ? '1 : left_mag[SAMPLE_WIDTH-2:0];
    end

    always_ff @(posedge clk) begin
        if (reset || bus.peak_clear) begin
            peak_level_reg <= '0;
        end else if (sample_valid_reg && (peak_mag > peak_level_reg)) begin
            peak_level_reg <= peak_mag;
        end
    end

    assign bus.peak_level = peak_level_reg;
`endif
endmodule
